// File: rtl/mac_row_ctrl.sv
// Row controller for a MAC tile row: streams col weights, then len activations, into the row
// and gates output FIFO writes from the last column's valid until len results are collected.
module mac_row_ctrl #(
  parameter int unsigned bw  = 4,
  parameter int unsigned col = 8,
  parameter int unsigned aw  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [aw-1:0]   len,
  output logic            busy,
  output logic            done,
  output logic            w_rd_en,
  output logic [aw-1:0]   w_addr,
  input  logic [bw-1:0]   w_data,
  output logic            x_rd_en,
  output logic [aw-1:0]   x_addr,
  input  logic [bw-1:0]   x_data,
  output logic [bw-1:0]   row_in_w,
  output logic [1:0]      row_inst_w,
  input  logic [col-1:0]  row_valid,
  output logic            ofifo_wr
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StGap   = 3'd2;
  localparam logic [2:0] StExec  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [aw-1:0] LastCol = aw'(col - 1);

  logic [2:0]    state_q, state_d;
  logic [aw-1:0] len_q;
  logic [aw-1:0] rd_cnt_q;
  logic [aw:0]   out_cnt_q;
  logic          w_ph_q, x_ph_q;
  logic          rd_en;
  logic          unused_valid;

  // Only the last column's valid marks a finished result.
  assign unused_valid = ^row_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (rd_cnt_q == LastCol) state_d = StGap;
      StGap:   state_d = (len_q != '0) ? StExec : StDone;
      StExec:  if (rd_cnt_q == len_q - aw'(1)) state_d = StDrain;
      StDrain: if (out_cnt_q == {1'b0, len_q}) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign w_rd_en = (state_q == StLoad);
  assign x_rd_en = (state_q == StExec);
  assign rd_en   = w_rd_en | x_rd_en;
  assign w_addr  = w_rd_en ? rd_cnt_q : '0;
  assign x_addr  = x_rd_en ? rd_cnt_q : '0;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);

  assign ofifo_wr = ((state_q == StExec) || (state_q == StDrain)) &&
                    (out_cnt_q < {1'b0, len_q}) && row_valid[col-1];

  // SRAM data arrives one cycle after the read, so the phase flags are delayed to match.
  assign row_inst_w = {x_ph_q, w_ph_q};

  always_comb begin
    row_in_w = '0;
    if (w_ph_q)      row_in_w = w_data;
    else if (x_ph_q) row_in_w = x_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      w_ph_q    <= 1'b0;
      x_ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_ph_q  <= w_rd_en;
      x_ph_q  <= x_rd_en;
      if ((state_q == StIdle) && start) len_q <= len;
      // Address restarts at 0 whenever a read phase ends, so each phase begins clean.
      rd_cnt_q <= (rd_en && (state_d == state_q)) ? rd_cnt_q + aw'(1) : '0;
      if (state_q == StIdle)  out_cnt_q <= '0;
      else if (ofifo_wr)      out_cnt_q <= out_cnt_q + (aw+1)'(1);
    end
  end

endmodule

// File: tb/tb_mac_row_ctrl.sv
// Randomized bench for mac_row_ctrl: a cycle-indexed pass model predicts every output.
module tb_mac_row_ctrl;

  localparam int unsigned BW  = 4;
  localparam int unsigned COL = 8;
  localparam int unsigned AW  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   len;
  logic            busy, done;
  logic            w_rd_en, x_rd_en;
  logic [AW-1:0]   w_addr, x_addr;
  logic [BW-1:0]   w_data = '0;
  logic [BW-1:0]   x_data = '0;
  logic [BW-1:0]   row_in_w;
  logic [1:0]      row_inst_w;
  logic [COL-1:0]  row_valid;
  logic            ofifo_wr;

  logic [BW-1:0] wmem [256];
  logic [BW-1:0] xmem [256];

  int vectors = 0;
  int miscompares = 0;

  // Pass model: mk = cycles since the accepted start (-1 when idle).
  int mk = -1;
  int mlen = 0;
  int mcnt = 0;
  bit dfp = 1'b0;

  mac_row_ctrl #(.bw(BW), .col(COL), .aw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .x_rd_en(x_rd_en), .x_addr(x_addr), .x_data(x_data),
    .row_in_w(row_in_w), .row_inst_w(row_inst_w), .row_valid(row_valid),
    .ofifo_wr(ofifo_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
    if (x_rd_en) x_data <= xmem[x_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".w_rd_en"}, w_rd_en, 0);
    chk({tag, ".w_addr"}, w_addr, 0);
    chk({tag, ".x_rd_en"}, x_rd_en, 0);
    chk({tag, ".x_addr"}, x_addr, 0);
    chk({tag, ".row_inst_w"}, row_inst_w, 0);
    chk({tag, ".row_in_w"}, row_in_w, 0);
    chk({tag, ".ofifo_wr"}, ofifo_wr, 0);
  endtask

  task automatic step(input logic st, input logic [AW-1:0] ln);
    int k;
    bit isdone, win, ew, ex, eof;
    int ewa, exa, einst, edata;
    start = st;
    len = ln;
    row_valid = COL'($urandom);
    @(negedge clk);
    k = mk;
    isdone = 0; ew = 0; ex = 0; eof = 0; ewa = 0; exa = 0; einst = 0; edata = 0;
    if (mk >= 0) begin
      isdone = (mlen == 0) ? (k == COL + 1) : ((k >= COL + mlen + 2) && dfp);
      ew  = (k < COL);
      ewa = ew ? k : 0;
      ex  = (k >= COL + 1) && (k <= COL + mlen);
      exa = ex ? k - COL - 1 : 0;
      if (k >= 1 && k <= COL) begin
        einst = 1; edata = int'(wmem[k-1]);
      end else if (k >= COL + 2 && k <= COL + mlen + 1) begin
        einst = 2; edata = int'(xmem[k-COL-2]);
      end
      win = (mlen > 0) && (k >= COL + 1) && !isdone;
      eof = win && (mcnt < mlen) && row_valid[COL-1];
    end
    chk("busy", busy, (mk >= 0) ? 1 : 0);
    chk("done", done, isdone);
    chk("w_rd_en", w_rd_en, ew);
    chk("w_addr", w_addr, ewa);
    chk("x_rd_en", x_rd_en, ex);
    chk("x_addr", x_addr, exa);
    chk("row_inst_w", row_inst_w, einst);
    chk("row_in_w", row_in_w, edata);
    chk("ofifo_wr", ofifo_wr, eof);
    if (mk < 0) begin
      if (st) begin
        mk = 0; mlen = int'(ln); mcnt = 0; dfp = 0;
      end
    end else if (isdone) begin
      mk = -1;
    end else begin
      dfp = (k >= COL + mlen + 1) && (mcnt == mlen);
      if (eof) mcnt++;
      mk++;
    end
    @(posedge clk);
    #1;
  endtask

  // Random start pulses with random len are thrown in mid-pass; they must be ignored.
  task automatic run_pass(input logic [AW-1:0] ln);
    int n;
    n = 0;
    step(1'b1, ln);
    while (mk >= 0 && n < 3000) begin
      step(($urandom_range(0, 3) == 0), AW'($urandom));
      n++;
    end
    chk("pass_timeout", (mk < 0), 1);
    for (int i = 0; i < 2; i++) step(1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      wmem[i] = BW'(i + 1);
      xmem[i] = BW'($urandom);
    end
    reset = 1'b0;
    start = 1'b0;
    len = '0;
    row_valid = '1;
    #3;
    chk_zero("por");
    #9;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, '0);

    run_pass(AW'(4));
    run_pass(AW'(0));
    run_pass(AW'(1));
    for (int i = 0; i < 5; i++) run_pass(AW'($urandom_range(1, 20)));
    run_pass(AW'(255));

    // Asynchronous reset mid-EXEC at x_addr == 2.
    step(1'b1, AW'(6));
    for (int i = 0; i < 40 && mk != COL + 3; i++) step(1'b0, '0);
    chk("pre_reset.x_addr", x_addr, 2);
    row_valid = '1;
    reset = 1'b0;
    #1;
    chk_zero("mid_reset");
    mk = -1;
    step(1'b0, '0);
    step(1'b0, '0);
    reset = 1'b1;
    step(1'b0, '0);
    run_pass(AW'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_row_ctrl.md
MAC_ROW_CTRL -- requirements
Module: mac_row_ctrl

Interface
REQ-001 SHALL have parameter bw, default 4, weight/activation width.
REQ-002 SHALL have parameter col, default 8, number of tiles in the controlled row.
REQ-003 SHALL have parameter aw, default 8, SRAM address width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to run one kernel-load + execute pass.
REQ-007 SHALL have port len  input  aw  number of activation vectors, sampled on accepted start.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-010 SHALL have port w_rd_en  output  1  weight SRAM read enable.
REQ-011 SHALL have port w_addr  output  aw  weight SRAM address.
REQ-012 SHALL have port w_data  input  bw  weight SRAM read data, valid 1 cycle after w_rd_en.
REQ-013 SHALL have port x_rd_en  output  1  activation SRAM read enable.
REQ-014 SHALL have port x_addr  output  aw  activation SRAM address.
REQ-015 SHALL have port x_data  input  bw  activation SRAM read data, valid 1 cycle after x_rd_en.
REQ-016 SHALL have port row_in_w  output  bw  data to row west input.
REQ-017 SHALL have port row_inst_w  output  2  row instruction: bit1 execute, bit0 kernel load.
REQ-018 SHALL have port row_valid  input  col  row per-column valid.
REQ-019 SHALL have port ofifo_wr  output  1  output FIFO write strobe.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, GAP, EXEC, DRAIN, DONE.
REQ-021 IDLE: start=1 SHALL latch len, clear counters, enter LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-022 LOAD: SHALL assert w_rd_en for exactly col cycles, w_addr 0..col-1 incrementing; then enter GAP.
REQ-023 GAP: exactly 1 cycle, no reads; then EXEC if latched len>0, else DONE.
REQ-024 EXEC: SHALL assert x_rd_en for exactly len cycles, x_addr 0..len-1; then DRAIN.
REQ-025 Read-phase flags SHALL be registered one cycle so row_inst_w=2'b01 and row_in_w=w_data in the cycle after each w_rd_en, row_inst_w=2'b10 and row_in_w=x_data in the cycle after each x_rd_en; otherwise row_inst_w=2'b00, row_in_w=0.
REQ-026 ofifo_wr SHALL equal row_valid[col-1] while state is EXEC or DRAIN and out count < len, else 0.
REQ-027 Out counter (aw+1 bits) SHALL increment on each ofifo_wr cycle; DRAIN SHALL exit to DONE in the cycle after out count reaches len.
REQ-028 row_valid pulses outside EXEC/DRAIN or beyond len SHALL be ignored (no write, no count).
REQ-029 DONE: SHALL assert done for 1 cycle, busy low next cycle, return to IDLE; start in DONE ignored.
REQ-030 busy SHALL be high in LOAD, GAP, EXEC, DRAIN, DONE.
REQ-031 len=2^aw-1 SHALL work without counter overflow; address counters SHALL NOT wrap during a pass.

Reset
REQ-032 reset low SHALL asynchronously force IDLE, counters 0, all outputs 0, including row_inst_w=2'b00, mid-pass.
REQ-033 After reset release, first accepted start SHALL begin a fresh pass with addresses from 0.

Verification
REQ-034 col=8, start, len=4, row_valid[7] pulsed 4 cycles during EXEC/DRAIN -> w_addr 0..7, 1 GAP cycle, x_addr 0..3, 4 ofifo_wr, single done pulse.
REQ-035 Weight SRAM model returning addr+1 -> row_in_w sequence 1..8 with row_inst_w=01 each cycle, aligned 1 cycle after w_rd_en.
REQ-036 start with len=0 -> LOAD 8 cycles, GAP, DONE; no x_rd_en, no ofifo_wr; busy high 10 cycles.
REQ-037 start pulses during LOAD and EXEC, extra row_valid[7] pulses after count reached -> ignored; counts and done timing unchanged.
REQ-038 reset low during EXEC at x_addr=2 -> outputs 0 immediately; after release, new start restarts at w_addr 0.
